stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Start/stop/clear counter that produces the 0–99 binary value consumed by the two-digit 7-segment display driver. It takes two raw push-buttons and synchronises and debounces each one. A prescaled tick advances a 7-bit count that wraps from 99 to 0. It sits directly upstream of the display driver, and its `value` output connects to the driver's 7-bit binary input.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count increment (1 Hz at 50 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles required to accept a button level change; must be ≥ 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `btn_start_stop` input 1: raw button, active-high, asynchronous to `clk`.
- `btn_clear` input 1: raw button, active-high, asynchronous to `clk`.
- `value` output 7: current count, 0–99; never exceeds 99.
- `running` output 1: high while in RUN.
- `wrap` output 1: one-cycle pulse on the 99→0 transition.

## Operation
- Each button has its own path: a 2-FF synchroniser (`s1`, `s2`), then a debouncer, then a rising-edge detector.
- Debouncer:
  - The counter increments while `s2` ≠ the debounced level `deb`.
  - The counter returns to 0 whenever `s2` = `deb`.
  - On the edge where the counter equals `DEBOUNCE_CYCLES`−1 and `s2` ≠ `deb`, `deb` takes `s2` and the counter clears.
  - The press pulse is `deb & ~deb_q`, where `deb_q` is `deb` delayed by one cycle. It is high for exactly one cycle per accepted press. Release generates no event.
- FSM states: IDLE (reset state), RUN, PAUSE.
  - In IDLE, a start_stop press moves to RUN.
  - In RUN, a start_stop press moves to PAUSE.
  - In PAUSE, a start_stop press moves to RUN.
  - A clear press in any state moves to IDLE, sets `value` to 0 and sets the prescaler to 0.
- Simultaneous clear and start_stop presses: clear wins and the start_stop press is discarded.
- Prescaler `pre`:
  - Counts only while the current state is RUN.
  - On the edge where `pre` = `TICK_DIV`−1: `pre` goes to 0 and `value` increments.
  - Holds its value in PAUSE, so resume continues the partial period.
- Tick and a start_stop press (RUN→PAUSE) on the same edge: the increment still occurs, because the tick is evaluated against the current state.
- Tick and a clear press on the same edge: clear wins and `value` = 0.
- Wrap: when `value` = 99 and a tick occurs, `value` becomes 0 and `wrap` is 1 for that one cycle.
- `running` is registered and equals (state == RUN).

## Timing
- Reset values:
  - Outputs: `value` = 0, `running` = 0, `wrap` = 0.
  - Internal: state IDLE, `pre` = 0, all synchroniser, debounce and edge registers 0.
- Button latency: the raw input is first sampled high at edge 1. `deb` rises at edge `DEBOUNCE_CYCLES`+2, and the state and `running` update at edge `DEBOUNCE_CYCLES`+3.
- First increment: occurs `TICK_DIV` edges after the edge that entered RUN from IDLE.
- Glitch rejection: any `s2` excursion shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- Reset asserted mid-operation: immediate asynchronous return to the reset values.
- Button held through reset release: the debouncer accepts it after the normal latency and it counts as one press.

## Structure
- Package `stopwatch_pkg`:
  - State encoding constants: IDLE, RUN, PAUSE.
  - `MAX_VALUE` = 99.
  - `VALUE_W` = 7.
- Sub-module `btn_debounce`:
  - Contains the synchroniser, debounce counter and edge detector, with parameter `DEBOUNCE_CYCLES`.
  - Outputs `press`.
  - Instantiated twice.
- Counter widths are `$clog2(TICK_DIV)` and `$clog2(DEBOUNCE_CYCLES)`.

## Test plan
All scenarios use `TICK_DIV` = 4 and `DEBOUNCE_CYCLES` = 3.
- Reset: hold `rst_n` low with buttons toggling → `value` = 0, `running` = 0, `wrap` = 0 throughout; after release, no state change with buttons low.
- Clean start: `btn_start_stop` high from edge 1 → `running` = 1 after edge 6; `value` = 1 after edge 10 and 2 after edge 14.
- Bounce: 2-cycle high pulses on `btn_start_stop` separated by 2 low cycles, repeated 10 times → `running` stays 0.
- Wrap: run 100 ticks → `value` steps 98, 99, 0; `wrap` = 1 only in the cycle where `value` first reads 0; counting continues to 1.
- Pause and resume:
  - Pause with `pre` = 2 → `value` frozen for 50 cycles.
  - Resume → next increment 2 edges after the RUN entry edge.
- Clear priority:
  - Clear and start_stop pressed on the same cycle in RUN at `value` = 37 → IDLE, `value` = 0, `running` = 0.
  - `rst_n` pulsed low mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter and its helpers.
package stopwatch_pkg;

    // Counter value width and the largest value shown on the two-digit display.
    localparam int VALUE_W   = 7;
    localparam int MAX_VALUE = 99;

    // Stopwatch control states; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage : stopwatch_pkg

// File: rtl/btn_debounce.sv
// One push-button path: 2-FF synchroniser, stable-level debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             s1;
    logic             s2;
    logic             deb;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (s2 != deb) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Delayed copy of deb for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b0;
        end else begin
            deb_q <= deb;
        end
    end

    // Only the press (rising debounced level) is an event; release is ignored.
    assign press = deb & ~deb_q;

endmodule : btn_debounce

// File: rtl/stopwatch_counter.sv
// Start/stop/clear stopwatch producing a 0..99 count for the display driver.
// A prescaler divides clk into count ticks while the FSM is in RUN.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start_stop,
    input  logic               btn_clear,
    output logic [VALUE_W-1:0] value,
    output logic               running,
    output logic               wrap
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic             ss_press;
    logic             clr_press;
    state_t           state;
    logic [PRE_W-1:0] pre;
    logic             tick;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_start_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_start_stop),
        .press (ss_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .press (clr_press)
    );

    // Tick is judged against the current state, so a pause on the tick edge still counts.
    assign tick = (state == RUN) && (pre == PRE_W'(TICK_DIV - 1));

    // Control FSM with prescaler and count; clear overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            pre     <= '0;
            value   <= '0;
            wrap    <= 1'b0;
        end else if (clr_press) begin
            state   <= IDLE;
            running <= 1'b0;
            pre     <= '0;
            value   <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (state == RUN) begin
                if (tick) begin
                    pre <= '0;
                    if (value == VALUE_W'(MAX_VALUE)) begin
                        value <= '0;
                        wrap  <= 1'b1;
                    end else begin
                        value <= value + 1'b1;
                    end
                end else begin
                    pre <= pre + 1'b1;
                end
            end
            if (ss_press) begin
                case (state)
                    IDLE, PAUSE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : stopwatch_counter

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A behavioural model is compared every negedge; directed literal checks pin it.
module tb_stopwatch_counter;

    localparam int TD = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic [6:0] value;
    logic       running;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_counter #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .value          (value),
        .running        (running),
        .wrap           (wrap)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Raw samples are kept as a history (bit 0 = this edge).
    // A debounced level flips when the DC samples taken 2..DC+1 edges ago all
    // disagree with it; a rise becomes a press acted on at the following edge.
    logic [7:0] hs = '0;
    logic [7:0] hc = '0;
    bit  mdeb_s = 0, mdeb_c = 0, mrose_s = 0, mrose_c = 0;
    int  mstate = 0;  // 0 idle, 1 run, 2 pause
    int  mpre = 0, mval = 0;
    bit  mwrap = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs = '0; hc = '0;
            mdeb_s = 0; mdeb_c = 0; mrose_s = 0; mrose_c = 0;
            mstate = 0; mpre = 0; mval = 0; mwrap = 0;
        end else begin
            bit ps, pc, all_s, all_c;
            ps = mrose_s;
            pc = mrose_c;
            hs = {hs[6:0], btn_start_stop};
            hc = {hc[6:0], btn_clear};
            all_s = 1; all_c = 1;
            for (int k = 2; k <= DC + 1; k++) begin
                if (hs[k] == mdeb_s) all_s = 0;
                if (hc[k] == mdeb_c) all_c = 0;
            end
            mrose_s = 0; mrose_c = 0;
            if (all_s) begin mdeb_s = !mdeb_s; mrose_s = mdeb_s; end
            if (all_c) begin mdeb_c = !mdeb_c; mrose_c = mdeb_c; end
            if (pc) begin
                mstate = 0; mval = 0; mpre = 0; mwrap = 0;
            end else begin
                mwrap = 0;
                if (mstate == 1) begin
                    mpre = mpre + 1;
                    if (mpre == TD) begin
                        mpre  = 0;
                        mwrap = (mval == 99);
                        mval  = (mval + 1) % 100;
                    end
                end
                if (ps) mstate = (mstate == 1) ? 2 : 1;
            end
        end
    end

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        chk("model_value", int'(value), mval);
        chk("model_running", int'(running), (mstate == 1) ? 1 : 0);
        chk("model_wrap", int'(wrap), int'(mwrap));
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_ss();
        btn_start_stop = 1'b1;
        cyc(4);
        btn_start_stop = 1'b0;
    endtask

    initial begin
        // Reset held with buttons toggling
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_start_stop = i[0];
            btn_clear      = ~i[0];
            chk("rst_value", int'(value), 0);
            chk("rst_running", int'(running), 0);
            chk("rst_wrap", int'(wrap), 0);
        end
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        rst_n          = 1'b1;
        cyc(10);
        chk("idle_running", int'(running), 0);
        chk("idle_value", int'(value), 0);

        // Clean start: raw high from edge 1
        btn_start_stop = 1'b1;
        cyc(5);
        chk("start_e5_running", int'(running), 0);
        cyc(1);
        chk("start_e6_running", int'(running), 1);
        cyc(2);
        btn_start_stop = 1'b0;
        cyc(1);
        chk("start_e9_value", int'(value), 0);
        cyc(1);
        chk("start_e10_value", int'(value), 1);
        cyc(4);
        chk("start_e14_value", int'(value), 2);

        // Clear back to idle, then bounce must be rejected
        btn_clear = 1'b1;
        cyc(4);
        btn_clear = 1'b0;
        cyc(6);
        chk("clear_running", int'(running), 0);
        chk("clear_value", int'(value), 0);
        for (int i = 0; i < 10; i++) begin
            btn_start_stop = 1'b1;
            cyc(2);
            btn_start_stop = 1'b0;
            cyc(2);
        end
        cyc(10);
        chk("bounce_running", int'(running), 0);

        // Wrap: RUN entry at edge 6, value k at edge 6+4k
        press_ss();
        cyc(2);
        chk("wrap_entry_running", int'(running), 1);
        cyc(392);
        chk("wrap_value98", int'(value), 98);
        cyc(4);
        chk("wrap_value99", int'(value), 99);
        chk("wrap_pre", int'(wrap), 0);
        cyc(4);
        chk("wrap_value0", int'(value), 0);
        chk("wrap_pulse", int'(wrap), 1);
        btn_start_stop = 1'b1;          // pause lands two edges after next tick
        cyc(1);
        chk("wrap_pulse_end", int'(wrap), 0);
        cyc(3);
        chk("wrap_value1", int'(value), 1);
        btn_start_stop = 1'b0;
        cyc(2);
        chk("pause_running", int'(running), 0);

        // Paused with pre = 2: value frozen
        cyc(50);
        chk("pause_frozen", int'(value), 1);

        // Resume: next tick two edges after RUN entry
        press_ss();
        cyc(2);
        chk("resume_running", int'(running), 1);
        cyc(1);
        chk("resume_e1_value", int'(value), 1);
        cyc(1);
        chk("resume_e2_value", int'(value), 2);

        // Clear + start_stop together at value 37
        cyc(136);
        btn_start_stop = 1'b1;
        btn_clear      = 1'b1;
        cyc(4);
        chk("prio_value37", int'(value), 37);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        cyc(2);
        chk("prio_value", int'(value), 0);
        chk("prio_running", int'(running), 0);
        cyc(10);
        chk("prio_stays_idle", int'(running), 0);

        // Asynchronous reset mid-RUN
        press_ss();
        cyc(6);
        chk("arst_pre_value", int'(value), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_value", int'(value), 0);
        chk("arst_running", int'(running), 0);
        chk("arst_wrap", int'(wrap), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("post_arst_running", int'(running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_counter
